// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED bank scheduler.
package led_sched_pkg;

  localparam int LED_W   = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One-hot vector for a requester index; callers narrow it to NREQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (last+1) mod NREQ.
module led_rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             req_any,
  output logic [IDX_W-1:0] pick
);

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    req_any = |req;
    pick    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) pick = IDX_W'((int'(last) + k) % NREQ);
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// Time-slices the 8-LED bank between NREQ pattern requesters with round-robin
// ownership, a one-cycle dark gap between owners and a global PWM brightness.
// Optional: define LED_SCHEDULER_HEARTBEAT_EN to blink LED7 from a 9-bit tick
// counter while no requester owns the bank.
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TICK_DIV    = 12000,
  parameter int SLICE_TICKS = 250,
  parameter int PWM_BITS    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] pattern,
  input  logic [PWM_BITS-1:0]   duty,
  output logic [NREQ-1:0]       grant,
  output logic                  tick,
  output logic [LED_W-1:0]      LED
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SL_W  = (SLICE_TICKS > 1) ? $clog2(SLICE_TICKS) : 1;

  state_t              state;
  logic [IDX_W-1:0]    last;
  logic [PRE_W-1:0]    presc;
  logic [SL_W-1:0]     slice_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                req_any;
  logic [IDX_W-1:0]    pick;
  logic                pwm_on;
  logic                slice_end;
  logic [LED_W-1:0]    owner_pat;
  logic [LED_W-1:0]    idle_led;

  led_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .last    (last),
    .req_any (req_any),
    .pick    (pick)
  );

  assign tick      = (presc == PRE_W'(TICK_DIV - 1));
  assign pwm_on    = (duty == '1) || (pwm_cnt < duty);
  assign slice_end = tick && (slice_cnt == SL_W'(SLICE_TICKS - 1));
  assign owner_pat = pattern[int'(last)*LED_W +: LED_W];

  // Free-running tick prescaler, independent of scheduler state.
  always_ff @(posedge CLK) begin
    if (RST)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Free-running PWM phase counter.
  always_ff @(posedge CLK) begin
    if (RST) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

`ifdef LED_SCHEDULER_HEARTBEAT_EN
  logic [8:0] hb_cnt;

  // Tick counter whose MSB gives a slow idle heartbeat on LED7.
  always_ff @(posedge CLK) begin
    if (RST)       hb_cnt <= '0;
    else if (tick) hb_cnt <= hb_cnt + 1'b1;
  end

  assign idle_led = {hb_cnt[8] & pwm_on, {(LED_W-1){1'b0}}};
`else
  assign idle_led = '0;
`endif

  // Ownership FSM with registered grant and LED drive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '0;
      LED       <= '0;
      last      <= IDX_W'(NREQ - 1);
      slice_cnt <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          LED <= (state == IDLE) ? idle_led : '0;
          if (req_any) begin
            state     <= GRANT;
            grant     <= NREQ'(onehot(3'(pick)));
            last      <= pick;
            slice_cnt <= '0;
          end else begin
            state <= IDLE;
            grant <= '0;
          end
        end
        GRANT: begin
          // An early drop and a slice-end tick on the same cycle share one gap.
          if (!req[last] || slice_end) begin
            state <= GAP;
            grant <= '0;
            LED   <= '0;
          end else begin
            LED <= owner_pat & {LED_W{pwm_on}};
            if (tick) slice_cnt <= slice_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          LED   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_scheduler.sv
// Bench for led_scheduler: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural model.
module tb_led_scheduler;

  localparam int NREQ        = 4;
  localparam int TICK_DIV    = 4;
  localparam int SLICE_TICKS = 3;
  localparam int PWM_BITS    = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pattern = '0;
  logic [3:0]  duty = '0;
  logic [3:0]  grant;
  logic        tick;
  logic [7:0]  LED;

  led_scheduler #(
    .NREQ(NREQ), .TICK_DIV(TICK_DIV), .SLICE_TICKS(SLICE_TICKS), .PWM_BITS(PWM_BITS)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .pattern(pattern), .duty(duty),
    .grant(grant), .tick(tick), .LED(LED)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner index (-1 = bank free), ticks held, phase counters.
  int         m_owner = -1;
  int         m_last  = NREQ - 1;
  int         m_held  = 0;
  int         m_pre   = 0;
  int         m_pwm   = 0;
  logic [7:0] m_led   = '0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] duty;
    logic [3:0] g;
    logic [7:0] led;
    logic       tk;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_grant();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [31:0] pat,
                            input logic [3:0] d);
    bit tk;
    bit on;
    tk = (m_pre == TICK_DIV - 1);
    on = (d == 4'hF) || (m_pwm < int'(d));
    if (r) begin
      m_owner = -1; m_last = NREQ - 1; m_held = 0; m_pre = 0; m_pwm = 0; m_led = '0;
      return;
    end
    m_pre = (m_pre + 1) % TICK_DIV;
    m_pwm = (m_pwm + 1) % 16;
    if (m_owner >= 0) begin
      if (!rq[m_owner] || (tk && m_held == SLICE_TICKS - 1)) begin
        m_owner = -1;
        m_led   = '0;
      end else begin
        m_led = pat[m_owner*8 +: 8] & {8{on}};
        if (tk) m_held++;
      end
    end else begin
      m_led = '0;
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (rq[idx]) begin
          m_owner = idx; m_last = idx; m_held = 0;
          break;
        end
      end
    end
  endtask

  task automatic step(input bit chk);
    logic r; logic [3:0] rq; logic [31:0] pat; logic [3:0] d;
    r = RST; rq = req; pat = pattern; d = duty;
    @(posedge CLK);
    model_step(r, rq, pat, d);
    #1;
    if (chk) begin
      check("grant", grant, m_grant());
      check("led", LED, m_led);
      check("tick", tick, (m_pre == TICK_DIV - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int off_cnt;

    tbl[0]  = '{1'b1, 4'b1111, 4'hF, 4'b0000, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 4'hF, 4'b0000, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 4'hF, 4'b0000, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 4'hF, 4'b0001, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b0};
    tbl[5]  = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b1};
    tbl[6]  = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b0};
    tbl[7]  = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b0};
    tbl[8]  = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b0};
    tbl[9]  = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b1};
    tbl[10] = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b0};
    tbl[11] = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b0};
    tbl[12] = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b0};
    tbl[13] = '{1'b0, 4'b0101, 4'hF, 4'b0001, 8'hA5, 1'b1};
    tbl[14] = '{1'b0, 4'b0101, 4'hF, 4'b0000, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 4'b0101, 4'hF, 4'b0100, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 4'b0101, 4'hF, 4'b0100, 8'h3C, 1'b0};

    pattern = {8'hF0, 8'h3C, 8'h81, 8'hA5};

    // Directed table: reset hold, release, slice rotation 0 -> 2.
    for (int i = 0; i < 17; i++) begin
      RST  = tbl[i].rst;
      req  = tbl[i].req;
      duty = tbl[i].duty;
      step(0);
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      check($sformatf("tbl%0d_led", i), LED, tbl[i].led);
      check($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
    end
    for (int i = 0; i < 30; i++) step(1);

    // Early drop by owner 1 while requester 3 waits.
    RST = 1'b1; step(1);
    RST = 1'b0; req = 4'b0010; step(1);
    check("ed_grant1", grant, 4'b0010);
    for (int i = 0; i < 5; i++) step(1);
    req = 4'b1010;
    for (int i = 0; i < 2; i++) step(1);
    req = 4'b1000; step(1);
    check("ed_gap_grant", grant, 4'b0000);
    check("ed_gap_led", LED, 8'h00);
    step(1);
    check("ed_next", grant, 4'b1000);
    for (int i = 0; i < 16; i++) step(1);

    // PWM: duty 4, then fully off, then fully on.
    RST = 1'b1; step(1);
    RST = 1'b0; req = 4'b0001; pattern = 32'h000000FF; duty = 4'd4;
    for (int i = 0; i < 64; i++) step(1);
    duty = 4'd0;
    off_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      step(1);
      if (LED != 8'h00) off_cnt++;
    end
    check("pwm_off_count", off_cnt, 0);
    duty = 4'hF;
    for (int i = 0; i < 48; i++) step(1);

    // Owner drops on the same cycle as its final slice tick.
    RST = 1'b1; step(1);
    RST = 1'b0; pattern = {8'hF0, 8'h3C, 8'h81, 8'hA5}; duty = 4'hF; req = 4'b0101;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (m_owner == 0 && m_held == SLICE_TICKS - 1 && m_pre == TICK_DIV - 1) found = 1'b1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL bnd_timeout: got no final-tick window want one within 60 cycles");
    end
    req = 4'b0100; step(1);
    check("bnd_gap", grant, 4'b0000);
    step(1);
    check("bnd_regrant", grant, 4'b0100);
    req = 4'b0000; step(1); step(1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("idle_grant", grant, 4'b0000);
      check("idle_led", LED, 8'h00);
    end

    // Reset while owner 1 holds the bank; requester 0 must win afterwards.
    RST = 1'b1; step(1);
    RST = 1'b0; req = 4'b0010; step(1);
    check("rg_grant", grant, 4'b0010);
    for (int i = 0; i < 3; i++) step(1);
    RST = 1'b1; req = 4'b0111; step(1);
    check("rg_rst_grant", grant, 4'b0000);
    check("rg_rst_led", LED, 8'h00);
    RST = 1'b0; step(1);
    check("rg_winner", grant, 4'b0001);

    // Randomized traffic against the model.
    RST = 1'b1; step(1);
    RST = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)   req = 4'($urandom);
      if ($urandom_range(0, 4) == 0)   pattern = $urandom;
      if ($urandom_range(0, 15) == 0)  duty = 4'($urandom);
      RST = ($urandom_range(0, 499) == 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
